// File: rtl/mips16_pipeline.sv
// 16-bit five-stage (IF/ID/EX/MEM/WB) MIPS-style core with internal Harvard memories.
// Forwarding, load-use stall, branch/jump flush and halt are all resolved in hardware.

// Instruction ROM; contents are loaded from outside the core and never touched by reset.
module instr_memory (
   input  logic [7:0]  pc,
   output logic [15:0] instr
);
   logic [15:0] instr_mem [0:255];

   assign instr = instr_mem[pc];
endmodule

// 8 x 16 register file; a same-cycle read of the register being written returns the new value.
module regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [2:0]  wa,
   input  logic [15:0] wd,
   input  logic [2:0]  ra1,
   input  logic [2:0]  ra2,
   output logic [15:0] rd1,
   output logic [15:0] rd2
);
   logic [15:0] RF [0:7];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) RF[i] <= 16'(i);
      end else if (we) begin
         RF[wa] <= wd;
      end
   end

   assign rd1 = (we && wa == ra1) ? wd : RF[ra1];
   assign rd2 = (we && wa == ra2) ? wd : RF[ra2];
endmodule

// 256-byte data memory: combinational little-endian word read, byte or word write on the edge.
module data_memory (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic        word,
   input  logic [7:0]  addr,
   input  logic [15:0] wd,
   output logic [15:0] rd
);
   logic [7:0] dmem [0:255];
   logic [7:0] addr_hi;

   // the upper byte of a word access wraps from 255 back to 0
   assign addr_hi = addr + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 8'(i);
      end else if (we) begin
         dmem[addr] <= wd[7:0];
         if (word) dmem[addr_hi] <= wd[15:8];
      end
   end

   assign rd = {dmem[addr_hi], dmem[addr]};
endmodule

module mips16_pipeline (
   input  logic clk,
   input  logic rst
);
   typedef struct packed {
      logic        vld;
      logic [7:0]  pc;
      logic [15:0] instr;
   } ifid_t;

   typedef struct packed {
      logic        vld;
      logic [7:0]  pc;
      logic [3:0]  op;
      logic [2:0]  funct;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  dest;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_byte;
      logic        mem_write;
      logic        branch;
      logic        branch_ne;
      logic        halt;
   } idex_t;

   typedef struct packed {
      logic        vld;
      logic [15:0] result;
      logic [15:0] sdata;
      logic [2:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_byte;
      logic        mem_write;
      logic        halt;
   } exmem_t;

   typedef struct packed {
      logic        vld;
      logic [15:0] data;
      logic [2:0]  dest;
      logic        reg_write;
      logic        halt;
   } memwb_t;

   typedef enum logic {S_RUN, S_DRAIN} state_t;

   state_t      state, state_nxt;
   logic [7:0]  pc, pc_nxt;
   logic [15:0] fetch_instr;
   ifid_t       if_id, if_id_nxt;
   idex_t       id_ex, id_ex_nxt, dec;
   exmem_t      ex_mem, ex_out;
   memwb_t      mem_wb, mem_out;

   logic [3:0]  opcode;
   logic        halt_wb;
   logic [2:0]  id_rs, id_rt, id_rd, id_funct;
   logic [15:0] rf_a, rf_b;
   logic        use_rs, use_rt, id_jump, id_halt, load_use;
   logic        wb_we;
   logic [15:0] ex_a, ex_b, ex_alu;
   logic        exm_fwd, wb_fwd;
   logic        br_taken;
   logic [7:0]  br_target;
   logic [15:0] dm_rd, ld_data;

   // ---------------- IF ----------------
   instr_memory instr_memory (.pc(pc), .instr(fetch_instr));

   // ---------------- ID ----------------
   assign opcode   = if_id.instr[15:12];
   assign id_rs    = if_id.instr[11:9];
   assign id_rt    = if_id.instr[8:6];
   assign id_rd    = if_id.instr[5:3];
   assign id_funct = if_id.instr[2:0];
   assign wb_we    = mem_wb.vld && mem_wb.reg_write;

   regfile regfile (
      .clk (clk),
      .rst (rst),
      .we  (wb_we),
      .wa  (mem_wb.dest),
      .wd  (mem_wb.data),
      .ra1 (id_rs),
      .ra2 (id_rt),
      .rd1 (rf_a),
      .rd2 (rf_b)
   );

   always_comb begin
      dec       = '0;
      use_rs    = 1'b0;
      use_rt    = 1'b0;
      dec.vld   = if_id.vld;
      dec.pc    = if_id.pc;
      dec.op    = opcode;
      dec.funct = id_funct;
      dec.rs    = id_rs;
      dec.rt    = id_rt;
      dec.a     = rf_a;
      dec.b     = rf_b;
      dec.imm   = {{10{if_id.instr[5]}}, if_id.instr[5:0]};
      if (if_id.vld) begin
         case (opcode)
            4'h0: begin
               dec.reg_write = 1'b1;
               dec.dest      = id_rd;
               use_rs        = 1'b1;
               use_rt        = 1'b1;
            end
            4'h1: begin
               if (id_funct == 3'b000) begin
                  dec.reg_write = 1'b1;
                  dec.dest      = id_rd;
                  use_rs        = 1'b1;
               end else if (id_funct == 3'b001) begin
                  dec.reg_write = 1'b1;
                  dec.dest      = id_rd;
                  use_rt        = 1'b1;
               end
            end
            4'hA, 4'hB: begin
               dec.mem_read  = 1'b1;
               dec.reg_write = 1'b1;
               dec.dest      = id_rt;
               dec.mem_byte  = opcode[0];
               use_rs        = 1'b1;
            end
            4'h4, 4'h5: begin
               dec.mem_write = 1'b1;
               dec.mem_byte  = ~opcode[0];
               use_rs        = 1'b1;
               use_rt        = 1'b1;
            end
            4'hE, 4'hF: begin
               dec.branch    = 1'b1;
               dec.branch_ne = opcode[0];
               use_rs        = 1'b1;
               use_rt        = 1'b1;
            end
            4'h9:    dec.halt = 1'b1;
            default: ;
         endcase
      end
   end

   assign id_jump  = if_id.vld && (opcode == 4'h8);
   assign id_halt  = dec.halt;
   assign load_use = id_ex.mem_read &&
                     ((use_rs && id_rs == id_ex.dest) || (use_rt && id_rt == id_ex.dest));

   // ---------------- EX ----------------
   // EX/MEM is checked last so the youngest producer overrides MEM/WB
   assign exm_fwd = ex_mem.vld && ex_mem.reg_write && !ex_mem.mem_read;
   assign wb_fwd  = mem_wb.vld && mem_wb.reg_write;

   always_comb begin
      ex_a = id_ex.a;
      ex_b = id_ex.b;
      if (wb_fwd && mem_wb.dest == id_ex.rs)  ex_a = mem_wb.data;
      if (wb_fwd && mem_wb.dest == id_ex.rt)  ex_b = mem_wb.data;
      if (exm_fwd && ex_mem.dest == id_ex.rs) ex_a = ex_mem.result;
      if (exm_fwd && ex_mem.dest == id_ex.rt) ex_b = ex_mem.result;
   end

   always_comb begin
      ex_alu = ex_a + id_ex.imm;
      if (id_ex.op == 4'h0) begin
         case (id_ex.funct)
            3'b000:  ex_alu = ex_a + ex_b;
            3'b001:  ex_alu = ex_a - ex_b;
            3'b010:  ex_alu = $signed(ex_a) >>> ex_b[3:0];
            3'b011:  ex_alu = ex_a >> ex_b[3:0];
            3'b100:  ex_alu = ex_a << ex_b[3:0];
            3'b101:  ex_alu = ex_a & ex_b;
            3'b110:  ex_alu = ex_a | ex_b;
            default: ex_alu = {15'd0, $signed(ex_a) < $signed(ex_b)};
         endcase
      end else if (id_ex.op == 4'h1) begin
         ex_alu = id_ex.funct[0] ? ex_b : ~ex_a;
      end
   end

   assign br_taken  = id_ex.branch && ((ex_a == ex_b) != id_ex.branch_ne);
   assign br_target = id_ex.pc + 8'd1 + id_ex.imm[7:0];

   always_comb begin
      ex_out           = '0;
      ex_out.vld       = id_ex.vld;
      ex_out.result    = ex_alu;
      ex_out.sdata     = ex_b;
      ex_out.dest      = id_ex.dest;
      ex_out.reg_write = id_ex.reg_write;
      ex_out.mem_read  = id_ex.mem_read;
      ex_out.mem_byte  = id_ex.mem_byte;
      ex_out.mem_write = id_ex.mem_write;
      ex_out.halt      = id_ex.halt;
   end

   // ---------------- MEM ----------------
   data_memory data_memory (
      .clk  (clk),
      .rst  (rst),
      .we   (ex_mem.vld && ex_mem.mem_write && !halt_wb),
      .word (!ex_mem.mem_byte),
      .addr (ex_mem.result[7:0]),
      .wd   (ex_mem.sdata),
      .rd   (dm_rd)
   );

   assign ld_data = ex_mem.mem_byte ? {{8{dm_rd[7]}}, dm_rd[7:0]} : dm_rd;

   always_comb begin
      mem_out           = '0;
      mem_out.vld       = ex_mem.vld;
      mem_out.data      = ex_mem.mem_read ? ld_data : ex_mem.result;
      mem_out.dest      = ex_mem.dest;
      mem_out.reg_write = ex_mem.reg_write;
      mem_out.halt      = ex_mem.halt;
   end

   // ---------------- WB / control ----------------
   assign halt_wb = mem_wb.halt;

   // a taken branch outranks the stall and any halt or jump sitting in ID
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc + 8'd1;
      if_id_nxt.vld   = 1'b1;
      if_id_nxt.pc    = pc;
      if_id_nxt.instr = fetch_instr;
      id_ex_nxt       = dec;
      if (br_taken) begin
         pc_nxt    = br_target;
         if_id_nxt = '0;
         id_ex_nxt = '0;
      end else if (load_use) begin
         pc_nxt    = pc;
         if_id_nxt = if_id;
         id_ex_nxt = '0;
      end else if (state == S_DRAIN) begin
         pc_nxt    = pc;
         if_id_nxt = '0;
      end else if (id_halt) begin
         pc_nxt    = pc;
         if_id_nxt = '0;
         state_nxt = S_DRAIN;
      end else if (id_jump) begin
         pc_nxt    = if_id.instr[7:0];
         if_id_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_RUN;
         pc     <= '0;
         if_id  <= '0;
         id_ex  <= '0;
         ex_mem <= '0;
         mem_wb <= '0;
      end else if (!halt_wb) begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         if_id  <= if_id_nxt;
         id_ex  <= id_ex_nxt;
         ex_mem <= ex_out;
         mem_wb <= mem_out;
      end
   end
endmodule

// File: tb/tb_mips16_pipeline.sv
// Directed programs for mips16_pipeline; expected architectural state is queued per program
// and compared against the register file, data memory and halt flag once the core halts.
module tb_mips16_pipeline;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cycles = 0;

   localparam logic [1:0] K_REG = 2'd0, K_MEM = 2'd1, K_HALT = 2'd2, K_CYC = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  idx;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];

   mips16_pipeline dut (.clk(clk), .rst(rst));

   always #5 clk = ~clk;

   task automatic push(input logic [1:0] kind, input logic [7:0] idx, input logic [15:0] val);
      exp_t e;
      e.kind = kind;
      e.idx  = idx;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      exp_t        e;
      logic [15:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            K_REG:   obs = dut.regfile.RF[e.idx[2:0]];
            K_MEM:   obs = {8'h00, dut.data_memory.dmem[e.idx]};
            K_HALT:  obs = {15'd0, dut.halt_wb};
            default: obs = 16'(cycles);
         endcase
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s kind=%0d idx=%0d observed=%h expected=%h", tag, e.kind, e.idx, obs, e.val);
         end
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) dut.instr_memory.instr_mem[i] = 16'h0000;
   endtask

   task automatic w(input logic [7:0] a, input logic [15:0] v);
      dut.instr_memory.instr_mem[a] = v;
   endtask

   task automatic wait_halt(input int budget);
      cycles = 0;
      while (dut.halt_wb !== 1'b1 && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic load_alu_prefix();
      clear_imem();
      w(1, 16'hB2C9); w(2, 16'hB508); w(3, 16'h0734); w(4, 16'h0728);
      w(5, 16'h073E); w(6, 16'h072D); w(7, 16'h1600); w(8, 16'h0717);
   endtask

   task automatic load_loop();
      clear_imem();
      w(1, 16'hB280); w(2, 16'hB8C6); w(3, 16'hB100); w(4, 16'h0699);
      w(5, 16'h08A0); w(6, 16'hF6BD); w(7, 16'h9000);
   endtask

   initial begin
      clear_imem();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) push(K_REG, 8'(i), 16'(i));
      push(K_HALT, 8'd0, 16'h0000);
      push(K_MEM, 8'd3, 16'h0003);
      push(K_MEM, 8'd200, 16'h00C8);
      drain("reset_state");

      // store data forwarded from an add that itself waited on a load
      clear_imem();
      w(1, 16'hB2C9); w(2, 16'hB508); w(3, 16'h0730); w(4, 16'h4382); w(5, 16'h9000);
      push(K_REG, 8'd3, 16'h000A);
      push(K_REG, 8'd4, 16'h000A);
      push(K_REG, 8'd6, 16'h0014);
      push(K_MEM, 8'd3, 16'h0014);
      push(K_HALT, 8'd0, 16'h0001);
      push(K_CYC, 8'd0, 16'd10);
      pulse_reset();
      wait_halt(200);
      drain("store_hazard");
      repeat (5) @(posedge clk);
      #1;
      push(K_HALT, 8'd0, 16'h0001);
      push(K_REG, 8'd6, 16'h0014);
      drain("frozen_after_halt");

      load_alu_prefix();
      w(9, 16'h9000);
      push(K_REG, 8'd0, 16'hFFF5);
      push(K_REG, 8'd1, 16'h0001);
      push(K_REG, 8'd2, 16'h0000);
      push(K_REG, 8'd3, 16'h000A);
      push(K_REG, 8'd4, 16'h000A);
      push(K_REG, 8'd5, 16'h000A);
      push(K_REG, 8'd6, 16'h2800);
      push(K_REG, 8'd7, 16'h000A);
      push(K_MEM, 8'd3, 16'h0003);
      pulse_reset();
      wait_halt(200);
      drain("alu");

      // sw/mov, then a word store and load that wrap at byte 255, then a negative lb
      load_alu_prefix();
      w(9, 16'h5382); w(10, 16'h1129); w(11, 16'h518A); w(12, 16'hA1CA);
      w(13, 16'hB080); w(14, 16'h9000);
      push(K_MEM, 8'd3, 16'h0000);
      push(K_MEM, 8'd4, 16'h0028);
      push(K_REG, 8'd5, 16'h000A);
      push(K_MEM, 8'd255, 16'h0000);
      push(K_MEM, 8'd0, 16'h0028);
      push(K_REG, 8'd7, 16'h2800);
      push(K_REG, 8'd2, 16'hFFF5);
      push(K_REG, 8'd0, 16'hFFF5);
      pulse_reset();
      wait_halt(200);
      drain("word_store_mov");

      load_loop();
      push(K_REG, 8'd2, 16'h0001);
      push(K_REG, 8'd3, 16'h0001);
      push(K_REG, 8'd4, 16'h0009);
      push(K_HALT, 8'd0, 16'h0001);
      push(K_CYC, 8'd0, 16'd51);
      pulse_reset();
      wait_halt(500);
      drain("branch_loop");

      clear_imem();
      w(1, 16'hB2C9); w(2, 16'hB508); w(3, 16'h8008); w(4, 16'h0734);
      w(5, 16'h0728); w(6, 16'h0738); w(7, 16'h4382); w(8, 16'h9000);
      push(K_REG, 8'd3, 16'h000A);
      push(K_REG, 8'd4, 16'h000A);
      push(K_REG, 8'd5, 16'h0005);
      push(K_REG, 8'd6, 16'h0006);
      push(K_REG, 8'd7, 16'h0007);
      push(K_MEM, 8'd3, 16'h0003);
      push(K_CYC, 8'd0, 16'd9);
      pulse_reset();
      wait_halt(200);
      drain("jump");

      load_loop();
      pulse_reset();
      repeat (20) @(posedge clk);
      #1;
      push(K_HALT, 8'd0, 16'h0000);
      drain("midrun_busy");
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) push(K_REG, 8'(i), 16'(i));
      push(K_HALT, 8'd0, 16'h0000);
      drain("midrun_reset");
      rst = 1'b0;
      push(K_REG, 8'd2, 16'h0001);
      push(K_REG, 8'd3, 16'h0001);
      push(K_REG, 8'd4, 16'h0009);
      push(K_HALT, 8'd0, 16'h0001);
      push(K_CYC, 8'd0, 16'd51);
      wait_halt(500);
      drain("midrun_restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
